// File: rtl/cfg_mux_n_icc_if.sv
// Serial-config / mux-data bundle for cfg_mux_n_icc; master drives config and inputs.
interface cfg_mux_n_icc_if #(
  parameter int N_IN = 16,
  parameter int CH   = 2
);
  logic                 prog;
  logic                 cfg_en;
  logic                 cfg_din;
  logic [CH*N_IN-1:0]   min;
  logic [CH-1:0]        ce;
  logic [CH-1:0]        mout;
  logic                 cfg_ok;
  logic                 cfg_err;
  logic [CH-1:0]        sel_err;

  modport master (
    output prog, cfg_en, cfg_din, min, ce,
    input  mout, cfg_ok, cfg_err, sel_err
  );

  modport slave (
    input  prog, cfg_en, cfg_din, min, ce,
    output mout, cfg_ok, cfg_err, sel_err
  );
endinterface

// File: rtl/cfg_mux_n_icc.sv
// Serially configured CH-channel N_IN:1 registered mux bank; one-clock datapath latency.
// Config is length-checked and committed atomically when prog drops; no backpressure.
module cfg_mux_n_icc #(
  parameter int N_IN = 16,
  parameter int CH   = 2
) (
  input  logic             clk,
  input  logic             rst,
  cfg_mux_n_icc_if.slave   bus
);
  localparam int SEL_W    = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int FW       = SEL_W + 2;
  localparam int CFG_BITS = CH * FW;
  localparam int CNT_W    = $clog2(CFG_BITS + 2);

  typedef enum logic [1:0] {IDLE, LOAD, ACTIVE, ERROR} state_t;

  state_t              state, state_nxt;
  logic [CFG_BITS-1:0] sr;
  logic [CFG_BITS-1:0] act;
  logic [CNT_W-1:0]    cnt;
  logic                cfg_ok_q, cfg_err_q;
  logic [CH-1:0]       mout_q;
  logic [CH-1:0]       pick;
  logic [CH-1:0]       sel_bad;
  logic                enter_load, shift, len_ok;
  logic [FW-1:0]       fld [CH];

  always_comb begin
    state_nxt  = state;
    enter_load = 1'b0;
    shift      = 1'b0;
    len_ok     = (cnt == CNT_W'(CFG_BITS));
    case (state)
      LOAD: begin
        shift = bus.prog && bus.cfg_en;
        if (!bus.prog) state_nxt = len_ok ? ACTIVE : ERROR;
      end
      default: begin
        if (bus.prog) begin
          state_nxt  = LOAD;
          enter_load = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Strobes on the edge that leaves LOAD are not shifted or counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr        <= '0;
      act       <= '0;
      cnt       <= '0;
      cfg_ok_q  <= 1'b0;
      cfg_err_q <= 1'b0;
    end else if (enter_load) begin
      cnt       <= '0;
      cfg_ok_q  <= 1'b0;
      cfg_err_q <= 1'b0;
    end else if (shift) begin
      sr <= {sr[CFG_BITS-2:0], bus.cfg_din};
      if (cnt != CNT_W'(CFG_BITS + 1)) cnt <= cnt + 1'b1;
    end else if (state == LOAD && !bus.prog) begin
      if (len_ok) begin
        act       <= sr;
        cfg_ok_q  <= 1'b1;
        cfg_err_q <= 1'b0;
      end else begin
        cfg_ok_q  <= 1'b0;
        cfg_err_q <= 1'b1;
      end
    end
  end

  always_comb begin
    for (int c = 0; c < CH; c++) fld[c] = act[c*FW +: FW];
  end

  // Explicit compare-and-pick keeps out-of-range selects from indexing past the channel.
  always_comb begin
    pick    = '0;
    sel_bad = '0;
    for (int c = 0; c < CH; c++) begin
      sel_bad[c] = {1'b0, fld[c][SEL_W-1:0]} >= (SEL_W+1)'(N_IN);
      for (int i = 0; i < N_IN; i++) begin
        if (fld[c][SEL_W-1:0] == SEL_W'(i)) pick[c] = bus.min[c*N_IN + i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mout_q <= '0;
    end else begin
      for (int c = 0; c < CH; c++) begin
        if (state != ACTIVE)
          mout_q[c] <= 1'b0;
        else if (bus.ce[c])
          mout_q[c] <= (fld[c][SEL_W+1] && !sel_bad[c]) ? (pick[c] ^ fld[c][SEL_W]) : 1'b0;
      end
    end
  end

  assign bus.mout    = mout_q;
  assign bus.cfg_ok  = cfg_ok_q;
  assign bus.cfg_err = cfg_err_q;
  assign bus.sel_err = (state == ACTIVE) ? sel_bad : '0;
endmodule

// File: tb/tb_cfg_mux_n_icc.sv
// Bench for cfg_mux_n_icc: a 16-input and a 12-input instance driven with identical stimulus.
module tb_cfg_mux_n_icc;
  localparam logic [11:0] WORD_A = 12'b100101_111100;
  localparam int M_IDLE = 0, M_LOAD = 1, M_ACT = 2, M_ERR = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        prog, cfg_en, cfg_din;
  logic [31:0] tb_min;
  logic [1:0]  tb_ce;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: mode, list of bits shifted in, committed word, expected outputs
  int          mode;
  bit          q[$];
  logic [11:0] m_cfg;
  logic        m_ok, m_err;
  logic [1:0]  e16, e12;

  cfg_mux_n_icc_if #(.N_IN(16), .CH(2)) b16 ();
  cfg_mux_n_icc_if #(.N_IN(12), .CH(2)) b12 ();

  assign b16.prog = prog;  assign b16.cfg_en = cfg_en;  assign b16.cfg_din = cfg_din;
  assign b16.min  = tb_min; assign b16.ce = tb_ce;
  assign b12.prog = prog;  assign b12.cfg_en = cfg_en;  assign b12.cfg_din = cfg_din;
  assign b12.min  = tb_min[23:0]; assign b12.ce = tb_ce;

  cfg_mux_n_icc #(.N_IN(16), .CH(2)) dut16 (.clk(clk), .rst(rst), .bus(b16.slave));
  cfg_mux_n_icc #(.N_IN(12), .CH(2)) dut12 (.clk(clk), .rst(rst), .bus(b12.slave));

  always #5 clk = ~clk;

  function automatic logic model_bit(logic [11:0] w, logic [31:0] mn, int nin, int c);
    int fld, sel;
    fld = int'(w >> (c*6)) & 63;
    sel = fld & 15;
    if (!fld[5] || sel >= nin) return 1'b0;
    return mn[c*nin + sel] ^ fld[4];
  endfunction

  function automatic logic [1:0] sel_exp(logic [11:0] w, int nin, int md);
    logic [1:0] r = 2'b00;
    if (md != M_ACT) return r;
    for (int c = 0; c < 2; c++) r[c] = ((int'(w >> (c*6)) & 15) >= nin);
    return r;
  endfunction

  task automatic model_reset();
    mode = M_IDLE; q.delete(); m_cfg = '0; m_ok = 1'b0; m_err = 1'b0; e16 = '0; e12 = '0;
  endtask

  task automatic model_edge(bit p, bit en, bit d);
    int pm = mode;
    if (pm == M_ACT) begin
      for (int c = 0; c < 2; c++) begin
        if (tb_ce[c]) begin
          e16[c] = model_bit(m_cfg, tb_min, 16, c);
          e12[c] = model_bit(m_cfg, tb_min, 12, c);
        end
      end
    end else begin
      e16 = '0; e12 = '0;
    end
    if (pm == M_LOAD) begin
      if (p) begin
        if (en) q.push_back(d);
      end else if (q.size() == 12) begin
        m_cfg = '0;
        foreach (q[i]) m_cfg = {m_cfg[10:0], q[i]};
        m_ok = 1'b1; m_err = 1'b0; mode = M_ACT;
      end else begin
        m_ok = 1'b0; m_err = 1'b1; mode = M_ERR;
      end
    end else if (p) begin
      mode = M_LOAD; q.delete(); m_ok = 1'b0; m_err = 1'b0;
    end
  endtask

  task automatic step(bit p, bit en, bit d);
    prog = p; cfg_en = en; cfg_din = d;
    @(posedge clk);
    model_edge(p, en, d);
    #1;
  endtask

  // Enter LOAD, shift nbits MSB first (idle gaps sprinkled in), then drop prog with a stray strobe.
  task automatic load(logic [11:0] w, int nbits);
    step(1, 0, 0);
    for (int i = 0; i < nbits; i++) begin
      tb_min = $urandom;
      if ($urandom_range(0, 3) == 0) step(1, 0, 1);
      step(1, 1, (i < 12) ? w[11-i] : bit'($urandom));
    end
    step(0, 1, bit'($urandom));
  endtask

  task automatic test_reset();
    tb_min = $urandom; tb_ce = 2'b11; prog = 0; cfg_en = 0; cfg_din = 0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    n_cmp++;
    if ({b16.mout, b12.mout} !== 4'b0000) begin
      n_bad++; $display("FAIL reset_mout: got %b want 0000", {b16.mout, b12.mout});
    end
    n_cmp++;
    if ({b16.cfg_ok, b16.cfg_err, b12.cfg_ok, b12.cfg_err} !== 4'b0000) begin
      n_bad++; $display("FAIL reset_status: got %b want 0000", {b16.cfg_ok, b16.cfg_err, b12.cfg_ok, b12.cfg_err});
    end
    n_cmp++;
    if ({b16.sel_err, b12.sel_err} !== 4'b0000) begin
      n_bad++; $display("FAIL reset_sel_err: got %b want 0000", {b16.sel_err, b12.sel_err});
    end
    for (int i = 0; i < 5; i++) begin
      tb_min = $urandom;
      step(0, 0, 0);
      n_cmp++;
      if ({b16.mout, b12.mout} !== 4'b0000) begin
        n_bad++; $display("FAIL idle_mout: got %b want 0000", {b16.mout, b12.mout});
      end
    end
  endtask

  task automatic test_good_load();
    logic prev21;
    tb_ce = 2'b11;
    load(WORD_A, 12);
    n_cmp++;
    if ({b16.cfg_ok, b16.cfg_err, b12.cfg_ok, b12.cfg_err} !== {m_ok, m_err, m_ok, m_err} || b16.cfg_ok !== 1'b1) begin
      n_bad++; $display("FAIL commit_status: got %b want %b", {b16.cfg_ok, b16.cfg_err, b12.cfg_ok, b12.cfg_err}, {m_ok, m_err, m_ok, m_err});
    end
    tb_min = $urandom | 32'h0000_1000;
    step(0, 0, 0);
    n_cmp++;
    if (b16.mout[0] !== 1'b0 || {b16.mout, b12.mout} !== {e16, e12}) begin
      n_bad++; $display("FAIL first_mout: got %b want %b", {b16.mout, b12.mout}, {e16, e12});
    end
    prev21 = tb_min[21];
    for (int i = 0; i < 8; i++) begin
      tb_min = $urandom;
      tb_min[21] = ~prev21;
      step(0, 0, 0);
      n_cmp++;
      if (b16.mout[1] !== tb_min[21] || {b16.mout, b12.mout} !== {e16, e12}) begin
        n_bad++; $display("FAIL follow_mout: got %b want %b", {b16.mout, b12.mout}, {e16, e12});
      end
      n_cmp++;
      if ({b16.sel_err, b12.sel_err} !== {sel_exp(m_cfg, 16, mode), sel_exp(m_cfg, 12, mode)}) begin
        n_bad++; $display("FAIL good_sel_err: got %b want %b", {b16.sel_err, b12.sel_err}, {sel_exp(m_cfg, 16, mode), sel_exp(m_cfg, 12, mode)});
      end
      prev21 = tb_min[21];
    end
  endtask

  task automatic test_wrong_length();
    int lens[2] = '{11, 13};
    foreach (lens[k]) begin
      load(12'($urandom), lens[k]);
      n_cmp++;
      if ({b16.cfg_ok, b16.cfg_err, b12.cfg_ok, b12.cfg_err} !== 4'b0101 || m_err !== 1'b1) begin
        n_bad++; $display("FAIL len%0d_status: got %b want 0101", lens[k], {b16.cfg_ok, b16.cfg_err, b12.cfg_ok, b12.cfg_err});
      end
      for (int i = 0; i < 3; i++) begin
        tb_min = $urandom;
        step(0, 0, 0);
        n_cmp++;
        if ({b16.mout, b12.mout} !== 4'b0000 || {e16, e12} !== 4'b0000) begin
          n_bad++; $display("FAIL len%0d_mout: got %b want 0000", lens[k], {b16.mout, b12.mout});
        end
      end
    end
  endtask

  task automatic test_sel_range();
    logic [11:0] w;
    w = {1'b1, 1'($urandom), 4'($urandom_range(0, 11)), 6'b101101};
    tb_ce = 2'b11;
    load(w, 12);
    for (int i = 0; i < 10; i++) begin
      tb_min = $urandom;
      step(0, 0, 0);
      n_cmp++;
      if (b12.sel_err !== 2'b01 || b16.sel_err !== 2'b00) begin
        n_bad++; $display("FAIL range_sel_err: got %b want 0001", {b16.sel_err, b12.sel_err});
      end
      n_cmp++;
      if (b12.mout[0] !== 1'b0 || {b16.mout, b12.mout} !== {e16, e12}) begin
        n_bad++; $display("FAIL range_mout: got %b want %b", {b16.mout, b12.mout}, {e16, e12});
      end
    end
  endtask

  task automatic test_enables();
    logic [1:0] held16, held12;
    tb_ce = 2'b11;
    load(WORD_A, 12);
    tb_min = $urandom;
    step(0, 0, 0);
    held16 = e16; held12 = e12;
    tb_ce = 2'b01;
    for (int i = 0; i < 6; i++) begin
      tb_min = $urandom;
      tb_min[21] = i[0]; tb_min[17] = ~i[0];
      step(0, 0, 0);
      n_cmp++;
      if (b16.mout[1] !== held16[1] || b12.mout[1] !== held12[1] || {b16.mout, b12.mout} !== {e16, e12}) begin
        n_bad++; $display("FAIL ce_hold: got %b want %b", {b16.mout, b12.mout}, {e16, e12});
      end
    end
    tb_ce = 2'b11;
    load({6'b000101, 6'b111100}, 12);
    for (int i = 0; i < 4; i++) begin
      tb_min = $urandom | 32'h0022_0000;
      step(0, 0, 0);
      n_cmp++;
      if (b16.mout[1] !== 1'b0 || b12.mout[1] !== 1'b0 || {b16.mout, b12.mout} !== {e16, e12}) begin
        n_bad++; $display("FAIL en_off: got %b want %b", {b16.mout, b12.mout}, {e16, e12});
      end
    end
  endtask

  task automatic test_reenter();
    tb_ce = 2'b11;
    load(WORD_A, 12);
    tb_min = 32'h0020_0000;
    step(0, 0, 0);
    step(1, 0, 0);
    n_cmp++;
    if (b16.mout[1] !== 1'b1 || {b16.mout, b12.mout} !== {e16, e12}) begin
      n_bad++; $display("FAIL reenter_edge1: got %b want %b", {b16.mout, b12.mout}, {e16, e12});
    end
    step(1, 0, 0);
    n_cmp++;
    if ({b16.mout, b12.mout} !== 4'b0000 || {b16.cfg_ok, b12.cfg_ok} !== 2'b00) begin
      n_bad++; $display("FAIL reenter_edge2: got %b want 000000", {b16.mout, b12.mout, b16.cfg_ok, b12.cfg_ok});
    end
  endtask

  task automatic test_rst_mid_load();
    tb_ce = 2'b11;
    load(WORD_A, 12);
    step(1, 0, 0);
    for (int i = 0; i < 6; i++) step(1, 1, bit'($urandom));
    rst = 1'b1;
    #2;
    n_cmp++;
    if ({b16.mout, b12.mout, b16.cfg_ok, b12.cfg_ok, b16.cfg_err, b12.cfg_err} !== 8'h00) begin
      n_bad++; $display("FAIL rst_async: got %b want 00000000", {b16.mout, b12.mout, b16.cfg_ok, b12.cfg_ok, b16.cfg_err, b12.cfg_err});
    end
    model_reset();
    cfg_en = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    load(WORD_A, 12);
    n_cmp++;
    if (b16.cfg_ok !== 1'b1 || b12.cfg_ok !== 1'b1 || m_cfg !== WORD_A) begin
      n_bad++; $display("FAIL rst_reload_ok: got %b want 11", {b16.cfg_ok, b12.cfg_ok});
    end
    for (int i = 0; i < 6; i++) begin
      tb_min = $urandom;
      step(0, 0, 0);
      n_cmp++;
      if ({b16.mout, b12.mout} !== {e16, e12}) begin
        n_bad++; $display("FAIL rst_reload_mout: got %b want %b", {b16.mout, b12.mout}, {e16, e12});
      end
    end
  endtask

  initial begin
    rst = 1'b1; prog = 0; cfg_en = 0; cfg_din = 0; tb_min = '0; tb_ce = '0;
    model_reset();
    test_reset();
    test_good_load();
    test_wrong_length();
    test_sel_range();
    test_enables();
    test_reenter();
    test_rst_mid_load();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
